// File: rtl/tamagotchi_btn_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : tamagotchi_pkg
//  Description: Shared constants and long-press state encoding for the
//               tamagotchi pushbutton conditioning stage.
//  Revision   : 1.0 - initial release
// ============================================================================
package tamagotchi_pkg;

  localparam logic [1:0] LP_IDLE  = 2'd0;
  localparam logic [1:0] LP_HOLD  = 2'd1;
  localparam logic [1:0] LP_FIRED = 2'd2;

  localparam int CLK_HZ       = 50000000;
  localparam int DEBOUNCE_MS  = 20;
  localparam int LONG_PRESS_S = 5;

  localparam int DEBOUNCE_CYC_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int LONG_CYC_DEF     = CLK_HZ * LONG_PRESS_S;

  // Maps a synchronised raw key sample to 1 = pressed.
  function automatic logic pressed(input logic raw, input logic active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tamagotchi_btn_cond_if.sv
`default_nettype none
// ============================================================================
//  Interface  : tamagotchi_btn_cond_if
//  Description: Raw board keys in, conditioned button levels/pulses out.
//               Optional press_* pulses exist when BTN_COND_PULSE_EN is defined.
//  Revision   : 1.0 - initial release
// ============================================================================
interface tamagotchi_btn_cond_if;

  logic key_salud_raw;
  logic key_energia_raw;
  logic key_hambre_raw;
  logic key_diversion_raw;
  logic key_reset_raw;
  logic key_test_raw;

  logic btn_salud;
  logic btn_energia;
  logic btn_hambre;
  logic btn_diversion;
  logic btn_reset;
  logic btn_test;
  logic hold_active;

`ifdef BTN_COND_PULSE_EN
  logic press_salud;
  logic press_energia;
  logic press_hambre;
  logic press_diversion;

  modport master (
    output key_salud_raw, key_energia_raw, key_hambre_raw,
           key_diversion_raw, key_reset_raw, key_test_raw,
    input  btn_salud, btn_energia, btn_hambre, btn_diversion,
           btn_reset, btn_test, hold_active,
           press_salud, press_energia, press_hambre, press_diversion
  );

  modport slave (
    input  key_salud_raw, key_energia_raw, key_hambre_raw,
           key_diversion_raw, key_reset_raw, key_test_raw,
    output btn_salud, btn_energia, btn_hambre, btn_diversion,
           btn_reset, btn_test, hold_active,
           press_salud, press_energia, press_hambre, press_diversion
  );
`else
  modport master (
    output key_salud_raw, key_energia_raw, key_hambre_raw,
           key_diversion_raw, key_reset_raw, key_test_raw,
    input  btn_salud, btn_energia, btn_hambre, btn_diversion,
           btn_reset, btn_test, hold_active
  );

  modport slave (
    input  key_salud_raw, key_energia_raw, key_hambre_raw,
           key_diversion_raw, key_reset_raw, key_test_raw,
    output btn_salud, btn_energia, btn_hambre, btn_diversion,
           btn_reset, btn_test, hold_active
  );
`endif

endinterface
`default_nettype wire

// File: rtl/tamagotchi_btn_cond_debounce.sv
`default_nettype none
// ============================================================================
//  Module     : btn_debounce
//  Description: 2-flop synchroniser, polarity normalisation and counter
//               debouncer for one raw key; o_level is 1 while pressed.
//  Revision   : 1.0 - initial release
// ============================================================================
module btn_debounce
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int ACTIVE_LOW   = 1
)(
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_key_raw,
  output logic      o_level
);

  localparam int             c_CW         = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(DEBOUNCE_CYC - 1);
  localparam logic           c_ACTIVE_LOW = (ACTIVE_LOW != 0);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic [c_CW-1:0] r_cnt;
  logic            w_s;

  // Synchroniser resets to the released level so reset release is edge-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= c_ACTIVE_LOW;
      r_sync2 <= c_ACTIVE_LOW;
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = pressed(r_sync2, c_ACTIVE_LOW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (w_s == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_stable <= w_s;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_stable;

endmodule
`default_nettype wire

// File: rtl/tamagotchi_btn_cond.sv
`default_nettype none
// ============================================================================
//  Module     : tamagotchi_btn_cond
//  Description: Debounces the six board keys, drives held action levels and
//               5 s long-press pulses for reset/test. Optional macro
//               BTN_COND_PULSE_EN adds one-cycle press_* rising-edge pulses.
//  Revision   : 1.0 - initial release
// ============================================================================
module tamagotchi_btn_cond
  import tamagotchi_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = LONG_CYC_DEF,
  parameter int ACTIVE_LOW   = 1
)(
  input wire logic              clk,
  input wire logic              rst,
  tamagotchi_btn_cond_if.slave  bus
);

  localparam int c_K_SALUD     = 0;
  localparam int c_K_ENERGIA   = 1;
  localparam int c_K_HAMBRE    = 2;
  localparam int c_K_DIVERSION = 3;
  localparam int c_K_RESET     = 4;
  localparam int c_K_TEST      = 5;
  localparam int c_N_KEYS      = 6;

  localparam int              c_HW         = $clog2(LONG_CYC + 1);
  localparam logic [c_HW-1:0] c_HCNT_ONE   = c_HW'(1);
  localparam logic [c_HW-1:0] c_HCNT_LAST  = c_HW'(LONG_CYC - 1);

  logic [c_N_KEYS-1:0] w_raw;
  logic [c_N_KEYS-1:0] w_level;

  assign w_raw = {bus.key_test_raw, bus.key_reset_raw, bus.key_diversion_raw,
                  bus.key_hambre_raw, bus.key_energia_raw, bus.key_salud_raw};

  for (genvar gi = 0; gi < c_N_KEYS; gi++) begin : g_key
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .i_key_raw (w_raw[gi]),
      .o_level   (w_level[gi])
    );
  end

  // Index 0 = reset key, 1 = test key; a held reset key parks the test FSM.
  logic [1:0] w_lp_level;
  logic [1:0] w_lp_force;
  logic [1:0] w_lp_pulse;
  logic [1:0] w_lp_hold;

  assign w_lp_level = {w_level[c_K_TEST], w_level[c_K_RESET]};
  assign w_lp_force = {w_level[c_K_RESET], 1'b0};

  for (genvar gl = 0; gl < 2; gl++) begin : g_lp
    logic [1:0]      r_state;
    logic [c_HW-1:0] r_hcnt;
    logic            r_pulse;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= LP_IDLE;
        r_hcnt  <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (w_lp_force[gl]) begin
          r_state <= LP_IDLE;
          r_hcnt  <= '0;
        end else begin
          case (r_state)
            LP_IDLE: begin
              if (w_lp_level[gl]) begin
                r_state <= LP_HOLD;
                r_hcnt  <= c_HCNT_ONE;
              end
            end
            LP_HOLD: begin
              if (!w_lp_level[gl]) begin
                r_state <= LP_IDLE;
                r_hcnt  <= '0;
              end else if (r_hcnt == c_HCNT_LAST) begin
                r_state <= LP_FIRED;
                r_hcnt  <= '0;
                r_pulse <= 1'b1;
              end else begin
                r_hcnt <= r_hcnt + 1'b1;
              end
            end
            LP_FIRED: begin
              if (!w_lp_level[gl]) r_state <= LP_IDLE;
            end
            default: begin
              r_state <= LP_IDLE;
              r_hcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign w_lp_pulse[gl] = r_pulse;
    assign w_lp_hold[gl]  = (r_state == LP_HOLD);
  end

  assign bus.btn_salud     = w_level[c_K_SALUD];
  assign bus.btn_energia   = w_level[c_K_ENERGIA];
  assign bus.btn_hambre    = w_level[c_K_HAMBRE];
  assign bus.btn_diversion = w_level[c_K_DIVERSION];
  assign bus.btn_reset     = w_lp_pulse[0];
  assign bus.btn_test      = w_lp_pulse[1];
  assign bus.hold_active   = |w_lp_hold;

`ifdef BTN_COND_PULSE_EN
  logic [3:0] r_level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_level_d <= '0;
    else     r_level_d <= w_level[3:0];
  end

  assign bus.press_salud     = w_level[c_K_SALUD]     & ~r_level_d[c_K_SALUD];
  assign bus.press_energia   = w_level[c_K_ENERGIA]   & ~r_level_d[c_K_ENERGIA];
  assign bus.press_hambre    = w_level[c_K_HAMBRE]    & ~r_level_d[c_K_HAMBRE];
  assign bus.press_diversion = w_level[c_K_DIVERSION] & ~r_level_d[c_K_DIVERSION];
`endif

endmodule
`default_nettype wire

// File: tb/tb_tamagotchi_btn_cond.sv
`default_nettype none
// ============================================================================
//  Module     : tb_tamagotchi_btn_cond
//  Description: Self-checking bench for tamagotchi_btn_cond with small
//               debounce/long-press constants.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_tamagotchi_btn_cond;

  localparam int DB = 4;
  localparam int LC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] raw = 6'h3f;   // bit0 salud .. bit3 diversion, bit4 reset, bit5 test

  always #5 clk = ~clk;

  tamagotchi_btn_cond_if bus_if ();

  assign bus_if.key_salud_raw     = raw[0];
  assign bus_if.key_energia_raw   = raw[1];
  assign bus_if.key_hambre_raw    = raw[2];
  assign bus_if.key_diversion_raw = raw[3];
  assign bus_if.key_reset_raw     = raw[4];
  assign bus_if.key_test_raw      = raw[5];

  tamagotchi_btn_cond #(
    .DEBOUNCE_CYC (DB),
    .LONG_CYC     (LC),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pressed-ness history, sliding debounce window and
  // run-length of each long-press key's effective held time.
  bit m_d1 [6];
  bit m_d2 [6];
  bit m_win [6][DB];
  bit m_st [6];
  int m_run [2];
  bit m_pulse [2];
  bit m_press [4];

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      m_d1[k] = 0; m_d2[k] = 0; m_st[k] = 0;
      for (int j = 0; j < DB; j++) m_win[k][j] = 0;
    end
    for (int i = 0; i < 2; i++) begin m_run[i] = 0; m_pulse[i] = 0; end
    for (int i = 0; i < 4; i++) m_press[i] = 0;
  endtask

  task automatic model_step();
    bit old_st [6];
    bit all_diff;
    bit eff [2];
    if (rst) begin
      model_reset();
      return;
    end
    old_st = m_st;
    for (int k = 0; k < 6; k++) begin
      for (int j = DB - 1; j > 0; j--) m_win[k][j] = m_win[k][j-1];
      m_win[k][0] = m_d2[k];
      all_diff = 1;
      for (int j = 0; j < DB; j++) if (m_win[k][j] == m_st[k]) all_diff = 0;
      if (all_diff) m_st[k] = ~m_st[k];
      m_d2[k] = m_d1[k];
      m_d1[k] = ~raw[k];
    end
    eff[0] = old_st[4];
    eff[1] = old_st[5] && !old_st[4];
    for (int i = 0; i < 2; i++) begin
      if (eff[i]) begin
        if (m_run[i] < 1000) m_run[i]++;
      end else begin
        m_run[i] = 0;
      end
      m_pulse[i] = (m_run[i] == LC);
    end
    for (int k = 0; k < 4; k++) m_press[k] = m_st[k] && !old_st[k];
  endtask

  function automatic logic [6:0] exp_vec();
    bit hold;
    hold = (m_run[0] >= 1 && m_run[0] < LC) || (m_run[1] >= 1 && m_run[1] < LC);
    return {m_st[0], m_st[1], m_st[2], m_st[3], m_pulse[0], m_pulse[1], hold};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {bus_if.btn_salud, bus_if.btn_energia, bus_if.btn_hambre,
            bus_if.btn_diversion, bus_if.btn_reset, bus_if.btn_test,
            bus_if.hold_active};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("model", 16'(dut_vec()), 16'(exp_vec()));
`ifdef BTN_COND_PULSE_EN
    check("press", {12'd0, bus_if.press_salud, bus_if.press_energia,
                    bus_if.press_hambre, bus_if.press_diversion},
          {12'd0, m_press[0], m_press[1], m_press[2], m_press[3]});
`endif
  endtask

  typedef struct {
    logic [5:0] raw;
    int         cycles;
    logic [6:0] exp;   // {salud, energia, hambre, diversion, reset, test, hold}
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [5:0] r, input int c, input logic [6:0] e);
    vec_t v;
    v.raw = r; v.cycles = c; v.exp = e;
    return v;
  endfunction

  initial begin
    int pulse_at;
    int pulse_cnt;
    logic [5:0] pat;
    int len;

    // Idle, clean salud press/release, four keys together.
    tbl.push_back(mk(6'b111111, 20, 7'b0000000));
    tbl.push_back(mk(6'b111110,  5, 7'b0000000));
    tbl.push_back(mk(6'b111110,  1, 7'b1000000));
    tbl.push_back(mk(6'b111111,  5, 7'b1000000));
    tbl.push_back(mk(6'b111111,  1, 7'b0000000));
    tbl.push_back(mk(6'b110000,  6, 7'b1111000));
    tbl.push_back(mk(6'b111111,  6, 7'b0000000));
    // Reset-key long press, 30 cycles held.
    tbl.push_back(mk(6'b101111,  6, 7'b0000000));
    tbl.push_back(mk(6'b101111,  1, 7'b0000001));
    tbl.push_back(mk(6'b101111,  8, 7'b0000001));
    tbl.push_back(mk(6'b101111,  1, 7'b0000100));
    tbl.push_back(mk(6'b101111, 14, 7'b0000000));
    tbl.push_back(mk(6'b111111, 10, 7'b0000000));
    // Short test press, 8 cycles.
    tbl.push_back(mk(6'b011111,  6, 7'b0000000));
    tbl.push_back(mk(6'b011111,  2, 7'b0000001));
    tbl.push_back(mk(6'b111111,  6, 7'b0000001));
    tbl.push_back(mk(6'b111111,  6, 7'b0000000));
    // Reset and test both held.
    tbl.push_back(mk(6'b001111,  6, 7'b0000000));
    tbl.push_back(mk(6'b001111,  9, 7'b0000001));
    tbl.push_back(mk(6'b001111,  1, 7'b0000100));
    tbl.push_back(mk(6'b001111, 14, 7'b0000000));
    tbl.push_back(mk(6'b111111, 10, 7'b0000000));

    // Power-on reset with all keys released.
    raw = 6'h3f;
    rst = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_outputs", 16'(dut_vec()), 16'd0);
    end
    rst = 1'b0;

    foreach (tbl[i]) begin
      raw = tbl[i].raw;
      repeat (tbl[i].cycles) step();
      check("table", 16'(dut_vec()), 16'(tbl[i].exp));
    end

    // Hunger key bounces every 2 cycles, then settles pressed.
    for (int i = 0; i < 12; i++) begin
      raw = 6'h3f;
      raw[2] = ((i / 2) % 2 == 1);
      step();
      check("bounce_low", 16'(bus_if.btn_hambre), 16'd0);
    end
    raw = 6'h3f;
    raw[2] = 1'b0;
    repeat (5) step();
    check("bounce_settle", 16'(bus_if.btn_hambre), 16'd0);
    step();
    check("bounce_rise", 16'(bus_if.btn_hambre), 16'd1);
    raw = 6'h3f;
    repeat (8) step();

    // Reset asserted in the middle of a reset-key hold.
    raw = 6'b101111;
    repeat (10) step();
    check("mid_hold", 16'(bus_if.hold_active), 16'd1);
    rst = 1'b1;
    step();
    check("rst_mid", 16'(dut_vec()), 16'd0);
    step();
    rst = 1'b0;
    pulse_at = 0;
    pulse_cnt = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (bus_if.btn_reset === 1'b1) begin
        pulse_cnt++;
        pulse_at = i;
      end
    end
    check("rehold_pulse_cnt", 16'(pulse_cnt), 16'd1);
    check("rehold_pulse_at", 16'(pulse_at), 16'd16);
    raw = 6'h3f;
    repeat (8) step();

    // Randomised segments with occasional bounce glitches and resets.
    for (int seg = 0; seg < 150; seg++) begin
      pat = 6'($urandom);
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
      end
      for (int c = 0; c < len; c++) begin
        raw = pat;
        if ($urandom_range(0, 11) == 0) raw = pat ^ (6'd1 << $urandom_range(0, 5));
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
